jtag_dbg_mailbox: RTL and testbench

- Debug-chain data register sitting directly downstream of the TAP controller's debug select.
- Consumes the TAP's serial TDI stream and its DR capture/shift/update strobes, and returns serial TDO into the TAP's debug TDI input.
- Decodes an opcode field on each DR update to move 32-bit words between the JTAG host and on-chip logic through two small FIFOs.
- FIFO user side is in the TCK domain; any CDC is outside this block.

---
 rtl/jtag_dbg_mailbox.sv | 161 ++++++++++++++++
 tb/tb_jtag_dbg_mailbox.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dbg_mailbox.sv
// rtl/jtag_dbg_mailbox.sv - JTAG debug DR mailbox with TX/RX word FIFOs in the TCK domain.
// Optional ID opcode (0x4) enabled by JTAG_DBG_MAILBOX_IDCODE_EN.
module jtag_dbg_mailbox #(
  parameter int          DATA_W  = 32,
  parameter int          DEPTH   = 4,
  parameter logic [31:0] MBOX_ID = 32'h4D42_0001
) (
  input  logic              tck_i,
  input  logic              rst_ni,
  input  logic              select_i,
  input  logic              capture_dr_i,
  input  logic              shift_dr_i,
  input  logic              update_dr_i,
  input  logic              tdi_i,
  output logic              tdo_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          SW       = DATA_W + 4;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0]  OP_WRITE = 4'h1;
  localparam logic [3:0]  OP_READ  = 4'h2;
  localparam logic [3:0]  OP_CLEAR = 4'h3;
  localparam logic [3:0]  OP_FLUSH = 4'hF;

  logic [SW-1:0]     sr_q, sr_d;
  logic [DATA_W-1:0] rd_hold_q, rd_hold_d;
  logic              rd_valid_q, rd_valid_d, ovf_q, ovf_d, udf_q, udf_d;

  logic [DATA_W-1:0] tx_mem_q [DEPTH];
  logic [DATA_W-1:0] rx_mem_q [DEPTH];
  logic [AW-1:0]     tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW-1:0]     rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [AW:0]       tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  logic       do_cap, do_shift, do_upd;
  logic [3:0] opcode;
  logic       op_write, op_read, op_clear, op_flush;
  logic       tx_full, tx_push, tx_pop, rx_empty, rx_push, rx_pop;

  assign do_cap   = select_i & capture_dr_i;
  assign do_shift = select_i & shift_dr_i & ~capture_dr_i;
  assign do_upd   = select_i & update_dr_i & ~capture_dr_i & ~shift_dr_i;
  assign opcode   = sr_q[3:0];
  assign op_write = do_upd & (opcode == OP_WRITE);
  assign op_read  = do_upd & (opcode == OP_READ);
  assign op_clear = do_upd & (opcode == OP_CLEAR);
  assign op_flush = do_upd & (opcode == OP_FLUSH);

  assign tx_full    = (tx_cnt_q == FULL_CNT);
  assign tx_valid_o = (tx_cnt_q != '0);
  assign tx_data_o  = tx_valid_o ? tx_mem_q[tx_rp_q] : '0;
  assign tx_pop     = tx_valid_o & tx_ready_i;
  // A full TX FIFO still accepts a WRITE when the consumer frees a slot this cycle.
  assign tx_push    = op_write & (~tx_full | tx_pop);

  assign rx_empty   = (rx_cnt_q == '0);
  assign rx_pop     = op_read & ~rx_empty;
  assign rx_ready_o = (rx_cnt_q != FULL_CNT) | rx_pop;
  assign rx_push    = rx_valid_i & rx_ready_o;

  assign tdo_o = sr_q[0];

  always_comb begin
    sr_d       = sr_q;
    rd_hold_d  = rd_hold_q;
    rd_valid_d = rd_valid_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    tx_wp_d    = tx_push ? tx_wp_q + AW'(1) : tx_wp_q;
    tx_rp_d    = tx_pop  ? tx_rp_q + AW'(1) : tx_rp_q;
    tx_cnt_d   = tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    rx_wp_d    = rx_push ? rx_wp_q + AW'(1) : rx_wp_q;
    rx_rp_d    = rx_pop  ? rx_rp_q + AW'(1) : rx_rp_q;
    rx_cnt_d   = rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);

    if (do_cap) begin
      sr_d = {rd_hold_q, udf_q, ovf_q, tx_full, rd_valid_q};
    end else if (do_shift) begin
      sr_d = {tdi_i, sr_q[SW-1:1]};
    end

    if (op_write && tx_full && !tx_ready_i) begin
      ovf_d = 1'b1;
    end
    if (op_read) begin
      if (!rx_empty) begin
        rd_hold_d  = rx_mem_q[rx_rp_q];
        rd_valid_d = 1'b1;
      end else begin
        udf_d      = 1'b1;
        rd_valid_d = 1'b0;
      end
    end
    if (op_clear) begin
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
      rd_valid_d = 1'b0;
    end
`ifdef JTAG_DBG_MAILBOX_IDCODE_EN
    if (do_upd && opcode == 4'h4) begin
      rd_hold_d  = DATA_W'(MBOX_ID);
      rd_valid_d = 1'b1;
    end
`endif
    if (op_flush) begin
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      tx_cnt_d = '0;
      rx_wp_d  = '0;
      rx_rp_d  = '0;
      rx_cnt_d = '0;
    end
  end

`ifndef JTAG_DBG_MAILBOX_IDCODE_EN
  logic unused_mbox_id;
  assign unused_mbox_id = ^MBOX_ID;
`endif

  always_ff @(posedge tck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q       <= '0;
      rd_hold_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
    end else begin
      sr_q       <= sr_d;
      rd_hold_q  <= rd_hold_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  // Storage needs no reset: entries are only observable through the counters.
  always_ff @(posedge tck_i) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= sr_q[SW-1:4];
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_data_i;
  end

endmodule

// File: tb/tb_jtag_dbg_mailbox.sv
// tb/tb_jtag_dbg_mailbox.sv - directed self-checking bench for jtag_dbg_mailbox.
module tb_jtag_dbg_mailbox;
  localparam logic [31:0] MBOX_ID = 32'h4D42_0001;

  logic        tck = 1'b0, rst_n = 1'b0;
  logic        select = 1'b0, cap = 1'b0, shf = 1'b0, upd = 1'b0, tdi = 1'b0;
  logic        tx_ready = 1'b0, rx_valid = 1'b0;
  logic [31:0] rx_data = '0;
  logic        tdo, tx_valid, rx_ready;
  logic [31:0] tx_data;
  logic [35:0] st;
  int          pass_cnt = 0, total_cnt = 0;

  jtag_dbg_mailbox #(.DATA_W(32), .DEPTH(4), .MBOX_ID(MBOX_ID)) dut (
    .tck_i(tck), .rst_ni(rst_n), .select_i(select), .capture_dr_i(cap),
    .shift_dr_i(shf), .update_dr_i(upd), .tdi_i(tdi), .tdo_o(tdo),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready)
  );

  always #5 tck = ~tck;

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  // Full capture/shift/update scan; dout is the captured status word.
  task automatic scan(input logic [35:0] din, input logic upd_ready, output logic [35:0] dout);
    select = 1'b1; cap = 1'b1;
    tick();
    cap = 1'b0; shf = 1'b1;
    for (int i = 0; i < 36; i++) begin
      dout[i] = tdo;
      tdi = din[i];
      tick();
    end
    shf = 1'b0; tdi = 1'b0; upd = 1'b1; tx_ready = upd_ready;
    tick();
    upd = 1'b0; tx_ready = 1'b0;
  endtask

  task automatic cmd(input logic [3:0] op, input logic [31:0] payload);
    logic [35:0] unused_dout;
    scan({payload, op}, 1'b0, unused_dout);
  endtask

  task automatic pop_tx();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic push_rx(input logic [31:0] d);
    rx_data = d; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    total_cnt++; if (tdo !== 1'b0) $display("FAIL reset_tdo got %b want 0", tdo); else pass_cnt++;
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", tx_valid); else pass_cnt++;
    total_cnt++; if (tx_data !== 32'h0) $display("FAIL reset_tx_data got %h want 0", tx_data); else pass_cnt++;
    total_cnt++; if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready got %b want 1", rx_ready); else pass_cnt++;
    scan(36'h0, 1'b0, st);
    total_cnt++; if (st !== 36'h0) $display("FAIL reset_status got %h want 0", st); else pass_cnt++;
  endtask

  task automatic test_write();
    cmd(4'h1, 32'hDEAD_BEEF);
    total_cnt++; if (tx_valid !== 1'b1) $display("FAIL write_valid got %b want 1", tx_valid); else pass_cnt++;
    total_cnt++; if (tx_data !== 32'hDEAD_BEEF) $display("FAIL write_data got %h want deadbeef", tx_data); else pass_cnt++;
    pop_tx();
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL write_pop_valid got %b want 0", tx_valid); else pass_cnt++;
    total_cnt++; if (tx_data !== 32'h0) $display("FAIL write_pop_data got %h want 0", tx_data); else pass_cnt++;
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 5; k++) cmd(4'h1, 32'(k));
    scan(36'h0, 1'b0, st);
    total_cnt++; if (st !== 36'h6) $display("FAIL ovf_status got %h want 6", st); else pass_cnt++;
    for (int k = 1; k <= 4; k++) begin
      total_cnt++;
      if (tx_valid !== 1'b1 || tx_data !== 32'(k))
        $display("FAIL ovf_drain%0d got v=%b d=%h want v=1 d=%h", k, tx_valid, tx_data, 32'(k));
      else pass_cnt++;
      pop_tx();
    end
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL ovf_drained got %b want 0", tx_valid); else pass_cnt++;
    cmd(4'h3, 32'h0);
    for (int k = 7; k <= 10; k++) cmd(4'h1, 32'(k));
    scan({32'd11, 4'h1}, 1'b1, st);
    scan(36'h0, 1'b0, st);
    total_cnt++; if (st !== 36'h2) $display("FAIL full_push_pop_status got %h want 2", st); else pass_cnt++;
    for (int k = 8; k <= 11; k++) begin
      total_cnt++;
      if (tx_valid !== 1'b1 || tx_data !== 32'(k))
        $display("FAIL full_drain%0d got v=%b d=%h want v=1 d=%h", k, tx_valid, tx_data, 32'(k));
      else pass_cnt++;
      pop_tx();
    end
  endtask

  task automatic test_read();
    push_rx(32'h1234_5678);
    cmd(4'h2, 32'h0);
    scan(36'h0, 1'b0, st);
    total_cnt++; if (st !== {32'h1234_5678, 4'h1}) $display("FAIL read_status got %h want 123456781", st); else pass_cnt++;
    cmd(4'h2, 32'h0);
    scan(36'h0, 1'b0, st);
    total_cnt++; if (st !== {32'h1234_5678, 4'h8}) $display("FAIL read_udf got %h want 123456788", st); else pass_cnt++;
    cmd(4'h3, 32'h0);
    scan(36'h0, 1'b0, st);
    total_cnt++; if (st !== {32'h1234_5678, 4'h0}) $display("FAIL read_clear got %h want 123456780", st); else pass_cnt++;
    for (int k = 0; k < 4; k++) push_rx(32'hA000_0000 + 32'(k));
    total_cnt++; if (rx_ready !== 1'b0) $display("FAIL rx_full_ready got %b want 0", rx_ready); else pass_cnt++;
    push_rx(32'hBAD0_BAD0);
    cmd(4'h2, 32'h0);
    scan(36'h0, 1'b0, st);
    total_cnt++; if (st !== {32'hA000_0000, 4'h1}) $display("FAIL rx_fifo_head got %h want a00000001", st); else pass_cnt++;
    cmd(4'hF, 32'h0);
    total_cnt++; if (rx_ready !== 1'b1) $display("FAIL flush_rx_ready got %b want 1", rx_ready); else pass_cnt++;
    cmd(4'h2, 32'h0);
    scan(36'h0, 1'b0, st);
    total_cnt++; if (st !== {32'hA000_0000, 4'h8}) $display("FAIL flush_read got %h want a00000008", st); else pass_cnt++;
    cmd(4'h1, 32'h77);
    cmd(4'hF, 32'h0);
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL flush_tx got %b want 0", tx_valid); else pass_cnt++;
    cmd(4'h3, 32'h0);
  endtask

  task automatic test_select();
    logic [35:0] pat;
    pat = {32'hCAFE_F00D, 4'h1};
    select = 1'b1; shf = 1'b1;
    for (int i = 0; i < 36; i++) begin
      tdi = pat[i];
      tick();
    end
    shf = 1'b0; tdi = 1'b0; select = 1'b0;
    cap = 1'b1; tick(); cap = 1'b0;
    shf = 1'b1; for (int i = 0; i < 5; i++) tick(); shf = 1'b0;
    upd = 1'b1; tick(); tick(); upd = 1'b0;
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL desel_no_push got %b want 0", tx_valid); else pass_cnt++;
    total_cnt++; if (tdo !== 1'b1) $display("FAIL desel_sr_hold got %b want 1", tdo); else pass_cnt++;
    select = 1'b1; upd = 1'b1; tick(); upd = 1'b0;
    total_cnt++;
    if (tx_valid !== 1'b1 || tx_data !== 32'hCAFE_F00D)
      $display("FAIL desel_sr_intact got v=%b d=%h want v=1 d=cafef00d", tx_valid, tx_data);
    else pass_cnt++;
    pop_tx();
  endtask

  task automatic test_idcode();
    push_rx(32'h600D_0001);
    cmd(4'h2, 32'h0);
    cmd(4'h4, 32'h0);
    scan(36'h0, 1'b0, st);
`ifdef JTAG_DBG_MAILBOX_IDCODE_EN
    total_cnt++; if (st !== {MBOX_ID, 4'h1}) $display("FAIL id_status got %h want %h", st, {MBOX_ID, 4'h1}); else pass_cnt++;
`else
    total_cnt++; if (st !== {32'h600D_0001, 4'h1}) $display("FAIL id_ignored got %h want 600d00011", st); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    cmd(4'h1, 32'h55);
    push_rx(32'h99);
    select = 1'b1; cap = 1'b1; tick(); cap = 1'b0;
    shf = 1'b1; tdi = 1'b1;
    for (int i = 0; i < 36; i++) tick();
    total_cnt++; if (tdo !== 1'b1) $display("FAIL mid_pre_tdo got %b want 1", tdo); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (tdo !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 32'h0 || rx_ready !== 1'b1)
      $display("FAIL mid_reset got tdo=%b txv=%b txd=%h rxr=%b want 0 0 0 1", tdo, tx_valid, tx_data, rx_ready);
    else pass_cnt++;
    shf = 1'b0; tdi = 1'b0; select = 1'b0;
    tick();
    rst_n = 1'b1;
    scan(36'h0, 1'b0, st);
    total_cnt++; if (st !== 36'h0) $display("FAIL mid_status got %h want 0", st); else pass_cnt++;
    cmd(4'h2, 32'h0);
    scan(36'h0, 1'b0, st);
    total_cnt++; if (st !== 36'h8) $display("FAIL mid_rx_empty got %h want 8", st); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_overflow();
    test_read();
    test_select();
    test_idcode();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
